// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and RAM signals around the memory arbiter
interface mem_arbiter_if;
  // instruction fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  // load/store port
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  // byte-wide RAM pins
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  // arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, ram_din,
    output if_done, if_inst, ls_done, ls_rdata, ram_dout, ram_a, ram_wr
  );

  // requester / RAM side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, ram_din,
    input  if_done, if_inst, ls_done, ls_rdata, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM arbiter for instruction fetch and load/store
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         jump_or_not,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  issued_q, issued_d;
  logic [2:0]  recv_q, recv_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic [31:0] next_addr;

  // byte address of the next beat; 32-bit add wraps past 0xFFFFFFFF
  assign next_addr = base_q + {29'd0, issued_q};

  // next-state and datapath for grant, byte-serial read and write sequencing
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    recv_d     = recv_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = ram_wr_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_inst_d  = if_inst_q;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      IDLE: begin
        // a done cycle is a turnaround: the finished requester is still dropping req
        if (!(if_done_q || ls_done_q)) begin
          if (bus.ls_req) begin
            state_d  = bus.ls_we ? LS_WR : LS_RD;
            base_d   = bus.ls_addr;
            wdata_d  = bus.ls_wdata;
            len_d    = (bus.ls_size == 2'd0) ? 3'd1 : (bus.ls_size == 2'd1) ? 3'd2 : 3'd4;
            issued_d = 3'd0;
            recv_d   = 3'd0;
            data_d   = 32'd0;
          end else if (bus.if_req && !jump_or_not) begin
            state_d  = IF_RD;
            base_d   = bus.if_addr;
            len_d    = 3'd4;
            issued_d = 3'd0;
            recv_d   = 3'd0;
            data_d   = 32'd0;
          end
        end
      end

      IF_RD, LS_RD: begin
        if (state_q == IF_RD && jump_or_not) begin
          // flushed fetch: drop it silently, if_inst keeps the last good word
          state_d  = IDLE;
          ram_a_d  = 32'd0;
          issued_d = 3'd0;
          recv_d   = 3'd0;
        end else begin
          if (issued_q < len_q) begin
            ram_a_d  = next_addr;
            issued_d = issued_q + 3'd1;
          end
          // ram_din answers the address driven one cycle earlier
          if (issued_q != 3'd0) begin
            data_d[{recv_q[1:0], 3'b000} +: 8] = bus.ram_din;
            recv_d = recv_q + 3'd1;
            if (recv_d == len_q) begin
              if (state_q == IF_RD) begin
                if_done_d = 1'b1;
                if_inst_d = data_d;
              end else begin
                ls_done_d  = 1'b1;
                ls_rdata_d = data_d;
              end
              state_d  = IDLE;
              ram_a_d  = 32'd0;
              issued_d = 3'd0;
              recv_d   = 3'd0;
            end
          end
        end
      end

      LS_WR: begin
        if (issued_q < len_q) begin
          ram_a_d    = next_addr;
          ram_dout_d = wdata_q[{issued_q[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
          issued_d   = issued_q + 3'd1;
        end else begin
          ram_wr_d   = 1'b0;
          ram_dout_d = 8'd0;
          ls_done_d  = 1'b1;
          state_d    = IDLE;
          issued_d   = 3'd0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // state register: reset wins, rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      issued_q   <= 3'd0;
      recv_q     <= 3'd0;
      len_q      <= 3'd0;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
      ram_a_q    <= 32'd0;
      ram_dout_q <= 8'd0;
      ram_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_inst_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      recv_q     <= recv_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_inst_q  <= if_inst_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign bus.ram_a    = ram_a_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized transaction-level check of mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic jump_or_not;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .jump_or_not(jump_or_not),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ram_arr [logic [31:0]];
  logic [7:0]  ref_arr [logic [31:0]];
  logic [31:0] exp_if_inst;
  logic [31:0] exp_ls_rdata;

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_arr.exists(a) ? ram_arr[a] : fill(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : fill(a);
  endfunction

  function automatic int nbytes(input bit is_if, input logic [1:0] size);
    if (is_if) return 4;
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // RAM device: commits a write in each cycle ram_wr is high, read data follows ram_a
  always @(negedge clk) begin
    if (bus.ram_wr) ram_arr[bus.ram_a] = bus.ram_dout;
    bus.ram_din = ram_rd(bus.ram_a);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram_arr[a] = d;
    ref_arr[a] = d;
  endtask

  task automatic drive_req(input bit is_if, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (is_if) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.ls_req   = 1'b1;
      bus.ls_we    = we;
      bus.ls_size  = size;
      bus.ls_addr  = addr;
      bus.ls_wdata = wdata;
    end
  endtask

  // Follows one granted transfer cycle by cycle; grant is the next posedge.
  // flush_at/stall_at: cycle after grant at which jump pulses / rdy drops for 3 cycles.
  task automatic expect_xfer(input bit is_if, input bit we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int flush_at, input int stall_at);
    int n;
    bit wr;
    logic done;
    logic [31:0] exp;
    logic [31:0] snap_a;
    logic snap_wr;
    n  = nbytes(is_if, size);
    wr = !is_if && we;
    @(posedge clk);
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      jump_or_not = 1'b0;
      done = is_if ? bus.if_done : bus.ls_done;
      if (k == 0) begin
        if (is_if) bus.if_addr = $urandom;
        else begin
          bus.ls_addr  = $urandom;
          bus.ls_wdata = $urandom;
          bus.ls_size  = 2'($urandom_range(0, 3));
          bus.ls_we    = 1'($urandom_range(0, 1));
        end
      end
      if (is_if && flush_at >= 0 && k == flush_at + 1) begin
        bus.if_req = 1'b0;
        chk("flush_ram_a", bus.ram_a, 32'd0);
        chk("flush_no_done", bus.if_done, 32'd0);
        chk("flush_inst_hold", bus.if_inst, exp_if_inst);
        return;
      end
      if (k >= 1 && k <= n) begin
        chk("ram_a", bus.ram_a, addr + 32'(k - 1));
        chk("ram_wr", bus.ram_wr, 32'(wr));
        if (wr) chk("ram_dout", bus.ram_dout, 32'(wdata[8*(k-1) +: 8]));
      end
      if (k <= n) chk("done_early", done, 32'd0);
      else begin
        chk("done", done, 32'd1);
        if (wr) begin
          chk("wr_end_ram_wr", bus.ram_wr, 32'd0);
          chk("wr_end_ram_dout", bus.ram_dout, 32'd0);
          for (int j = 0; j < n; j++) ref_arr[addr + 32'(j)] = wdata[8*j +: 8];
        end else begin
          exp = 32'd0;
          for (int j = 0; j < n; j++) exp[8*j +: 8] = ref_rd(addr + 32'(j));
          if (is_if) exp_if_inst = exp;
          else exp_ls_rdata = exp;
        end
        chk("if_inst", bus.if_inst, exp_if_inst);
        chk("ls_rdata", bus.ls_rdata, exp_ls_rdata);
        if (is_if) bus.if_req = 1'b0;
        else bus.ls_req = 1'b0;
      end
      if (k == flush_at) jump_or_not = 1'b1;
      if (k == stall_at) begin
        snap_a  = bus.ram_a;
        snap_wr = bus.ram_wr;
        rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ram_a", bus.ram_a, snap_a);
          chk("stall_ram_wr", bus.ram_wr, 32'(snap_wr));
          chk("stall_done", is_if ? bus.if_done : bus.ls_done, 32'd0);
        end
        rdy = 1'b1;
      end
    end
    @(negedge clk);
    chk("done_pulse", is_if ? bus.if_done : bus.ls_done, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          is_if;
    bit          we;
    bit          pair;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] if_a;
    int          fl;

    rst = 1'b1;
    rdy = 1'b1;
    jump_or_not  = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_size  = 2'd0;
    bus.ls_addr  = 32'd0;
    bus.ls_wdata = 32'd0;
    exp_if_inst  = 32'd0;
    exp_ls_rdata = 32'd0;

    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    preload(32'h0020, 8'hFF);
    preload(32'h2000, 8'h93); preload(32'h2001, 8'h00);
    preload(32'h2002, 8'h10); preload(32'h2003, 8'h00);

    repeat (2) @(negedge clk);
    chk("rst_ram_a", bus.ram_a, 32'd0);
    chk("rst_ram_wr", bus.ram_wr, 32'd0);
    chk("rst_ram_dout", bus.ram_dout, 32'd0);
    chk("rst_if_done", bus.if_done, 32'd0);
    chk("rst_ls_done", bus.ls_done, 32'd0);
    chk("rst_if_inst", bus.if_inst, 32'd0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // plain word fetch
    drive_req(1, 0, 2'd0, 32'h1000, 32'd0);
    expect_xfer(1, 0, 2'd0, 32'h1000, 32'd0, -1, -1);
    chk("fetch_0513", exp_if_inst, 32'h00000513);

    // simultaneous requests: load byte goes first, fetch follows
    drive_req(1, 0, 2'd0, 32'h1000, 32'd0);
    drive_req(0, 0, 2'd0, 32'h0020, 32'd0);
    expect_xfer(0, 0, 2'd0, 32'h0020, 32'd0, -1, -1);
    chk("load_ff", exp_ls_rdata, 32'h000000FF);
    expect_xfer(1, 0, 2'd0, 32'h1000, 32'd0, -1, -1);

    // half store across the top of the address space, then read it back
    drive_req(0, 1, 2'd1, 32'hFFFFFFFF, 32'h1234BEEF);
    expect_xfer(0, 1, 2'd1, 32'hFFFFFFFF, 32'h1234BEEF, -1, -1);
    drive_req(0, 0, 2'd1, 32'hFFFFFFFF, 32'd0);
    expect_xfer(0, 0, 2'd1, 32'hFFFFFFFF, 32'd0, -1, -1);
    chk("wrap_half", exp_ls_rdata, 32'h0000BEEF);

    // flush after two bytes addressed, then a fresh fetch
    drive_req(1, 0, 2'd0, 32'h1000, 32'd0);
    expect_xfer(1, 0, 2'd0, 32'h1000, 32'd0, 2, -1);
    drive_req(1, 0, 2'd0, 32'h2000, 32'd0);
    expect_xfer(1, 0, 2'd0, 32'h2000, 32'd0, -1, -1);
    chk("fetch_2000", exp_if_inst, 32'h00100093);

    // flush in IDLE blocks a same-cycle fetch grant
    drive_req(1, 0, 2'd0, 32'h1000, 32'd0);
    jump_or_not = 1'b1;
    @(negedge clk);
    jump_or_not = 1'b0;
    chk("jump_idle_no_done", bus.if_done, 32'd0);
    expect_xfer(1, 0, 2'd0, 32'h1000, 32'd0, -1, -1);

    // stalled word load
    drive_req(0, 0, 2'd2, 32'h2000, 32'd0);
    expect_xfer(0, 0, 2'd2, 32'h2000, 32'd0, -1, 2);
    chk("stall_load", exp_ls_rdata, 32'h00100093);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      is_if = ($urandom_range(0, 2) == 0);
      we    = 1'($urandom_range(0, 1));
      sz    = 2'($urandom_range(0, 3));
      wd    = $urandom;
      addr  = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3)))
                                          : (32'h4000 + 32'($urandom_range(0, 31)));
      fl    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nbytes(is_if, sz)) : -1;
      pair  = !is_if && ($urandom_range(0, 3) == 0);
      if_a  = 32'h4000 + 32'($urandom_range(0, 31));
      if (pair) drive_req(1, 0, 2'd0, if_a, 32'd0);
      drive_req(is_if, we, sz, addr, wd);
      expect_xfer(is_if, we, sz, addr, wd, fl, -1);
      if (pair) expect_xfer(1, 0, 2'd0, if_a, 32'd0, -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset in the middle of a word store, after its first byte
    drive_req(0, 1, 2'd2, 32'h3000, 32'hA1B2C3D4);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_wr", bus.ram_wr, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ls_req = 1'b0;
    chk("rst_mid_ram_wr", bus.ram_wr, 32'd0);
    chk("rst_mid_ram_a", bus.ram_a, 32'd0);
    chk("rst_mid_ram_dout", bus.ram_dout, 32'd0);
    chk("rst_mid_ls_done", bus.ls_done, 32'd0);
    ref_arr[32'h3000] = 8'hD4;
    exp_if_inst  = 32'd0;
    exp_ls_rdata = 32'd0;
    @(negedge clk);
    chk("rst_after_ls_done", bus.ls_done, 32'd0);
    chk("rst_after_if_inst", bus.if_inst, 32'd0);
    chk("rst_after_ls_rdata", bus.ls_rdata, 32'd0);
    drive_req(0, 0, 2'd2, 32'h3000, 32'd0);
    expect_xfer(0, 0, 2'd2, 32'h3000, 32'd0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
